paddle_motion_ctrl: RTL and testbench

Parametrised paddle position controller; successor to the fixed-step player paddle mover.
- Moves a paddle along one axis with a programmable tick rate.
- Speed ramps up while a direction is held, and the position saturates at both limits.
- Sits between the key-input synchroniser and the paddle renderer/collision logic; one instance per paddle.

---
 rtl/paddle_motion_ctrl.sv | 159 +++++++++++++++
 tb/tb_paddle_motion_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/paddle_motion_ctrl.sv
// paddle_motion_ctrl: one-axis paddle position controller with a tick divider,
// a hold-to-accelerate speed ramp and saturation at both position limits.
// Optional auto-track mode is compiled in with `define PADDLE_AUTO_TRACK_EN.
//
// Ports:
//   clock       system clock
//   reset_n     asynchronous active-low reset
//   in_play     1 = run, 0 = freeze position, ramp and tick phase
//   up / down   direction keys (toward MIN_POS / toward MAX_POS)
//   auto_mode   select auto-track (only with PADDLE_AUTO_TRACK_EN)
//   target_pos  auto-track target (only with PADDLE_AUTO_TRACK_EN)
//   pos         registered paddle position
//   moving      registered, 1 if pos changed on the last tick
//   at_min      combinational, pos == MIN_POS
//   at_max      combinational, pos == MAX_POS
module paddle_motion_ctrl #(
  parameter int unsigned POS_WIDTH   = 10,
  parameter int unsigned INIT_POS    = 220,
  parameter int unsigned MIN_POS     = 21,
  parameter int unsigned MAX_POS     = 459,
  parameter int unsigned TICK_DIV    = 4,
  parameter int unsigned MAX_SPEED   = 4,
  parameter int unsigned ACCEL_TICKS = 8,
  parameter int unsigned DEADBAND    = 2
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 in_play,
  input  logic                 up,
  input  logic                 down,
  input  logic                 auto_mode,
  input  logic [POS_WIDTH-1:0] target_pos,
  output logic [POS_WIDTH-1:0] pos,
  output logic                 moving,
  output logic                 at_min,
  output logic                 at_max
);

  localparam int unsigned EXT_W  = POS_WIDTH + 1;
  localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned HOLD_W = (ACCEL_TICKS > 1) ? $clog2(ACCEL_TICKS) : 1;
  localparam int unsigned SPD_W  = $clog2(MAX_SPEED + 1);

  typedef enum logic [1:0] {
    ST_STOP = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2
  } state_t;

  state_t              state, state_nxt, req;
  logic [SPD_W-1:0]    speed, speed_nxt;
  logic [HOLD_W-1:0]   hold_cnt, hold_cnt_nxt;
  logic [TICK_W-1:0]   tick_cnt, tick_cnt_nxt;
  logic [POS_WIDTH-1:0] pos_nxt;
  logic                moving_nxt;
  logic                tick;
  logic [EXT_W-1:0]    pos_ext, step, moved_pos;

  assign pos_ext = {1'b0, pos};
  assign at_min  = (pos == POS_WIDTH'(MIN_POS));
  assign at_max  = (pos == POS_WIDTH'(MAX_POS));

  // Direction request from keys or, when compiled in, from the tracking target
`ifdef PADDLE_AUTO_TRACK_EN
  logic [EXT_W-1:0] tgt_ext;
  assign tgt_ext = {1'b0, target_pos};

  always_comb begin
    req = ST_STOP;
    if (auto_mode) begin
      if (tgt_ext + EXT_W'(DEADBAND) < pos_ext)      req = ST_UP;
      else if (tgt_ext > pos_ext + EXT_W'(DEADBAND)) req = ST_DOWN;
    end else begin
      if (up && !down)      req = ST_UP;
      else if (down && !up) req = ST_DOWN;
    end
  end
`else
  logic unused_auto;
  assign unused_auto = ^{auto_mode, target_pos, POS_WIDTH'(DEADBAND)};

  always_comb begin
    req = ST_STOP;
    if (up && !down)      req = ST_UP;
    else if (down && !up) req = ST_DOWN;
  end
`endif

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_STOP;
      speed    <= SPD_W'(1);
      hold_cnt <= '0;
      tick_cnt <= '0;
      pos      <= POS_WIDTH'(INIT_POS);
      moving   <= 1'b0;
    end else begin
      state    <= state_nxt;
      speed    <= speed_nxt;
      hold_cnt <= hold_cnt_nxt;
      tick_cnt <= tick_cnt_nxt;
      pos      <= pos_nxt;
      moving   <= moving_nxt;
    end
  end

  // Tick divider, speed ramp and saturating move, all evaluated on a tick
  always_comb begin
    state_nxt    = state;
    speed_nxt    = speed;
    hold_cnt_nxt = hold_cnt;
    tick_cnt_nxt = tick_cnt;
    pos_nxt      = pos;
    moving_nxt   = moving;
    tick         = (tick_cnt == TICK_W'(TICK_DIV - 1));
    step         = EXT_W'(1);
    moved_pos    = pos_ext;

    if (!in_play) begin
      moving_nxt = 1'b0;
    end else begin
      tick_cnt_nxt = tick ? '0 : tick_cnt + TICK_W'(1);
      if (tick) begin
        state_nxt = req;
        if (req == ST_STOP) begin
          speed_nxt    = SPD_W'(1);
          hold_cnt_nxt = '0;
          moving_nxt   = 1'b0;
        end else begin
          if (req != state) begin
            // Start or reversal always begins with a unit step
            step         = EXT_W'(1);
            speed_nxt    = SPD_W'(1);
            hold_cnt_nxt = '0;
          end else begin
            step = EXT_W'(speed);
            if (hold_cnt == HOLD_W'(ACCEL_TICKS - 1)) begin
              hold_cnt_nxt = '0;
              speed_nxt    = (speed == SPD_W'(MAX_SPEED)) ? speed : speed + SPD_W'(1);
            end else begin
              hold_cnt_nxt = hold_cnt + HOLD_W'(1);
            end
          end

          // One extra bit keeps pos +/- step from wrapping before the clamp
          if (req == ST_UP) begin
            moved_pos = (pos_ext < EXT_W'(MIN_POS) + step) ? EXT_W'(MIN_POS) : pos_ext - step;
          end else begin
            moved_pos = (pos_ext + step > EXT_W'(MAX_POS)) ? EXT_W'(MAX_POS) : pos_ext + step;
          end
          pos_nxt    = POS_WIDTH'(moved_pos);
          moving_nxt = (moved_pos != pos_ext);
        end
      end
    end
  end

endmodule

// File: tb/tb_paddle_motion_ctrl.sv
// Bench for paddle_motion_ctrl: directed scenarios plus randomized key traffic,
// compared every cycle against a run-length based behavioural model.
module tb_paddle_motion_ctrl;

  localparam int unsigned PW    = 10;
  localparam int unsigned INITP = 220;
  localparam int unsigned MINP  = 21;
  localparam int unsigned MAXP  = 459;
  localparam int unsigned TD    = 4;
  localparam int unsigned MS    = 4;
  localparam int unsigned AT    = 8;
  localparam int unsigned DB    = 2;

  logic          clock;
  logic          reset_n;
  logic          in_play;
  logic          up;
  logic          down;
  logic          auto_mode;
  logic [PW-1:0] target_pos;
  logic [PW-1:0] pos;
  logic          moving;
  logic          at_min;
  logic          at_max;

  paddle_motion_ctrl #(
    .POS_WIDTH(PW), .INIT_POS(INITP), .MIN_POS(MINP), .MAX_POS(MAXP),
    .TICK_DIV(TD), .MAX_SPEED(MS), .ACCEL_TICKS(AT), .DEADBAND(DB)
  ) dut (
    .clock(clock), .reset_n(reset_n), .in_play(in_play), .up(up), .down(down),
    .auto_mode(auto_mode), .target_pos(target_pos), .pos(pos), .moving(moving),
    .at_min(at_min), .at_max(at_max)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model: speed derived from how many consecutive ticks one direction has held
  int m_pos, m_moving, m_dir, m_run, m_active, m_ticks;

  task automatic model_reset();
    m_pos = INITP; m_moving = 0; m_dir = 0; m_run = 0; m_active = 0;
  endtask

  function automatic int step_for_run(input int run);
    int s;
    s = (run >= 2) ? 1 + (run - 2) / AT : 1;
    return (s > MS) ? MS : s;
  endfunction

  task automatic model_clock();
    int req, np, st;
    if (!in_play) begin
      m_moving = 0;
      return;
    end
    m_active++;
    if (m_active % TD != 0) return;
    m_ticks++;
    req = 0;
`ifdef PADDLE_AUTO_TRACK_EN
    if (auto_mode) begin
      if (int'(target_pos) + DB < m_pos)      req = -1;
      else if (int'(target_pos) > m_pos + DB) req = 1;
    end else
`endif
    begin
      if (up && !down)      req = -1;
      else if (down && !up) req = 1;
    end
    if (req == 0) begin
      m_run = 0; m_moving = 0; m_dir = 0;
      return;
    end
    m_run = (req == m_dir) ? m_run + 1 : 1;
    m_dir = req;
    st = step_for_run(m_run);
    np = m_pos + req * st;
    if (np < int'(MINP)) np = MINP;
    if (np > int'(MAXP)) np = MAXP;
    m_moving = (np != m_pos);
    m_pos = np;
  endtask

  task automatic step();
    @(posedge clock);
    if (reset_n) model_clock();
    #1;
    check_val("pos", 32'(pos), 32'(m_pos));
    check_val("moving", 32'(moving), 32'(m_moving));
    check_val("at_min", 32'(at_min), 32'(m_pos == int'(MINP)));
    check_val("at_max", 32'(at_max), 32'(m_pos == int'(MAXP)));
  endtask

  task automatic hold_ticks(input logic u, input logic d, input int k);
    int goal, budget;
    up = u; down = d;
    goal = m_ticks + k;
    budget = k * TD + 2;
    while (m_ticks < goal && budget > 0) begin
      step();
      budget--;
    end
    if (m_ticks < goal) check_val("tick_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    model_reset();
    check_val("rst_pos", 32'(pos), 32'(INITP));
    check_val("rst_moving", 32'(moving), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  int p;
  int guard;

  initial begin
    m_ticks = 0;
    model_reset();
    reset_n = 1'b0; in_play = 1'b1; up = 1'b0; down = 1'b0;
    auto_mode = 1'b0; target_pos = '0;
    #12;
    check_val("reset_pos", 32'(pos), 32'd220);
    check_val("reset_moving", 32'(moving), 32'd0);
    check_val("reset_at_min", 32'(at_min), 32'd0);
    check_val("reset_at_max", 32'(at_max), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // Idle for 40 cycles
    for (int i = 0; i < 40; i++) step();
    check_val("idle_pos", 32'(pos), 32'd220);
    check_val("idle_moving", 32'(moving), 32'd0);

    // Hold up for 4 ticks: unit steps
    for (int i = 1; i <= 4; i++) begin
      hold_ticks(1'b1, 1'b0, 1);
      check_val("up_pos", 32'(pos), 32'(220 - i));
      check_val("up_moving", 32'(moving), 32'd1);
    end

    // Hold down 20 ticks from reset: ramp 1,1..,2..,3
    do_reset();
    hold_ticks(1'b0, 1'b1, 20);
    check_val("ramp_pos", 32'(pos), 32'd254);

    // Drive into the top limit, then press into it again
    guard = 0;
    up = 1'b1; down = 1'b0;
    while (m_pos != int'(MINP) && guard < 300) begin
      hold_ticks(1'b1, 1'b0, 1);
      guard++;
    end
    check_val("clamp_pos", 32'(pos), 32'd21);
    check_val("clamp_at_min", 32'(at_min), 32'd1);
    check_val("clamp_moving", 32'(moving), 32'd1);
    hold_ticks(1'b1, 1'b0, 1);
    check_val("limit_press_moving", 32'(moving), 32'd0);
    check_val("limit_press_pos", 32'(pos), 32'd21);

    // Both keys: no motion and the ramp restarts
    hold_ticks(1'b0, 1'b1, 12);
    p = m_pos;
    hold_ticks(1'b1, 1'b1, 1);
    check_val("both_pos", 32'(pos), 32'(p));
    check_val("both_moving", 32'(moving), 32'd0);
    hold_ticks(1'b0, 1'b1, 1);
    check_val("after_both_step", 32'(pos), 32'(p + 1));

    // Reversal down -> up steps by exactly one
    hold_ticks(1'b0, 1'b1, 12);
    p = m_pos;
    hold_ticks(1'b1, 1'b0, 1);
    check_val("reversal_step", 32'(pos), 32'(p - 1));

    // Freeze mid-hold: position, ramp and tick phase all hold
    hold_ticks(1'b0, 1'b1, 10);
    step();
    p = m_pos;
    in_play = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check_val("freeze_pos", 32'(pos), 32'(p));
      check_val("freeze_moving", 32'(moving), 32'd0);
    end
    in_play = 1'b1;
    for (int i = 0; i < int'(TD) - 2; i++) step();
    check_val("resume_no_tick", 32'(pos), 32'(p));
    step();
    check_val("resume_tick_pos", 32'(pos), 32'(p + 2));

    // Asynchronous reset mid-move
    up = 1'b0; down = 1'b1;
    step(); step();
    #2;
    reset_n = 1'b0;
    #1;
    check_val("async_rst_pos", 32'(pos), 32'd220);
    check_val("async_rst_moving", 32'(moving), 32'd0);
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;

`ifdef PADDLE_AUTO_TRACK_EN
    // Auto-track toward 100 settles within the dead zone
    do_reset();
    auto_mode = 1'b1; target_pos = PW'(100);
    hold_ticks(1'b0, 1'b0, 150);
    check_val("auto_settle", 32'(pos >= PW'(98) && pos <= PW'(102)), 32'd1);
    check_val("auto_moving", 32'(moving), 32'd0);
    auto_mode = 1'b0;
`endif

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(7) == 0) begin
        up   = 1'($urandom_range(1));
        down = 1'($urandom_range(1));
      end
      if ($urandom_range(15) == 0) in_play = ($urandom_range(9) != 0);
`ifdef PADDLE_AUTO_TRACK_EN
      if ($urandom_range(63) == 0) auto_mode = 1'($urandom_range(1));
      if ($urandom_range(127) == 0) target_pos = PW'($urandom_range(480));
`endif
      if ($urandom_range(999) == 0) begin
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_val("rand_async_rst", 32'(pos), 32'(INITP));
        @(negedge clock);
        reset_n = 1'b1;
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
